// File: rtl/ram_stream_reader.sv
// Burst read client for the dual-port ram_block: issues ce-gated reads and streams the data out.
// Optional macro RAM_STREAM_READER_LAST_EN adds an out_last marker on the final beat of a burst.
module ram_stream_reader #(
   parameter int DWIDTH    = 8,
   parameter int AWIDTH    = 13,
   parameter int MEM_SIZE  = 3072,
   parameter int LEN_WIDTH = AWIDTH + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AWIDTH-1:0]    cmd_base,
   input  logic [LEN_WIDTH-1:0] cmd_len,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   output logic [AWIDTH-1:0]    ram_addr,
   output logic                 ram_ce,
   output logic                 ram_we,
   output logic [DWIDTH-1:0]    ram_d,
   input  logic [DWIDTH-1:0]    ram_q,
   output logic [DWIDTH-1:0]    out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 done,
`ifdef RAM_STREAM_READER_LAST_EN
   output logic                 out_last,
`endif
   output logic                 err
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   localparam logic [AWIDTH:0]   MEM_SIZE_W = (AWIDTH+1)'(MEM_SIZE);
   localparam logic [AWIDTH-1:0] LAST_ADDR  = AWIDTH'(MEM_SIZE - 1);

   state_t               state_r;
   state_t               state_nxt_s;
   logic                 v0_r;
   logic                 v1_r;
   logic [AWIDTH-1:0]    addr_r;
   logic [LEN_WIDTH-1:0] issue_left_r;

   logic                 cmd_hs_s;
   logic                 base_bad_s;
   logic                 len_zero_s;
   logic                 adv_s;
   logic                 ce_s;
   logic                 last_issue_s;
   logic                 final_beat_s;
   logic [AWIDTH-1:0]    addr_inc_s;

   assign cmd_hs_s     = cmd_valid && (state_r == ST_IDLE);
   assign base_bad_s   = ({1'b0, cmd_base} >= MEM_SIZE_W);
   assign len_zero_s   = (cmd_len == {LEN_WIDTH{1'b0}});
   assign adv_s        = !v1_r || out_ready;
   assign ce_s         = adv_s && ((state_r == ST_READ) || (state_r == ST_DRAIN));
   assign last_issue_s = (issue_left_r == LEN_WIDTH'(1));
   // Nothing left in the first RAM stage, so the beat leaving the output stage is the last one.
   assign final_beat_s = v1_r && out_ready && !v0_r;
   assign addr_inc_s   = (addr_r == LAST_ADDR) ? {AWIDTH{1'b0}} : (addr_r + AWIDTH'(1));

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_hs_s) begin
               if (base_bad_s) begin
                  state_nxt_s = ST_ERR;
               end else if (len_zero_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_READ;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: begin
            if (ce_s && last_issue_s) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_READ;
            end
         end
         ST_DRAIN: begin
            if (final_beat_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         ST_ERR:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Issue address, issue counter and RAM pipeline valid tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r       <= {AWIDTH{1'b0}};
         issue_left_r <= {LEN_WIDTH{1'b0}};
         v0_r         <= 1'b0;
         v1_r         <= 1'b0;
      end else begin
         if (cmd_hs_s && !base_bad_s && !len_zero_s) begin
            addr_r       <= cmd_base;
            issue_left_r <= cmd_len;
         end else if (ce_s && (state_r == ST_READ)) begin
            issue_left_r <= issue_left_r - LEN_WIDTH'(1);
            // The last issued address is held through DRAIN.
            if (!last_issue_s) begin
               addr_r <= addr_inc_s;
            end else begin
               addr_r <= addr_r;
            end
         end else begin
            addr_r       <= addr_r;
            issue_left_r <= issue_left_r;
         end
         if (ce_s) begin
            v1_r <= v0_r;
            v0_r <= (state_r == ST_READ);
         end else begin
            v1_r <= v1_r;
            v0_r <= v0_r;
         end
      end
   end

`ifdef RAM_STREAM_READER_LAST_EN
   logic [LEN_WIDTH-1:0] beats_left_r;

   // Remaining output beats of the current burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beats_left_r <= {LEN_WIDTH{1'b0}};
      end else if (cmd_hs_s && !base_bad_s) begin
         beats_left_r <= cmd_len;
      end else if (v1_r && out_ready) begin
         beats_left_r <= beats_left_r - LEN_WIDTH'(1);
      end else begin
         beats_left_r <= beats_left_r;
      end
   end

   assign out_last = v1_r && (beats_left_r == LEN_WIDTH'(1));
`endif

   assign cmd_ready = (state_r == ST_IDLE);
   assign busy      = (state_r != ST_IDLE);
   assign done      = (state_r == ST_DONE);
   assign err       = (state_r == ST_ERR);
   assign ram_addr  = addr_r;
   assign ram_ce    = ce_s;
   assign ram_we    = 1'b0;
   assign ram_d     = {DWIDTH{1'b0}};
   assign out_data  = ram_q;
   assign out_valid = v1_r;

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side client for the dual-port `ram_block` memory.
- Takes a burst command (base address, length) on a valid/ready channel and drives one RAM port to issue reads.
- The RAM has 2-cycle, ce-gated read latency; the block tracks reads in flight and presents the data as a valid/ready stream with full backpressure.
- Sits between a RAM-backed buffer (weights, activations) and a streaming compute pipeline.

Parameters:
- DWIDTH, 8, RAM word width.
- AWIDTH, 13, RAM address width.
- MEM_SIZE, 3072, number of RAM words; valid addresses are 0..MEM_SIZE-1.
- LEN_WIDTH, AWIDTH+1, width of the burst-length field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_base  in  AWIDTH  burst start address.
- cmd_len  in  LEN_WIDTH  number of words to read.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- ram_addr  out  AWIDTH  RAM port address.
- ram_ce  out  1  RAM port chip enable; also advances the RAM output pipeline.
- ram_we  out  1  RAM write enable; constant 0.
- ram_d  out  DWIDTH  RAM write data; constant 0.
- ram_q  in  DWIDTH  RAM read data.
- out_data  out  DWIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, all in-flight valid bits 0, out_valid=0, ram_ce=0, ram_addr=0, busy=0, done=0, err=0, counters 0.
- FSM states and transitions:
  - IDLE → READ: on cmd handshake with len>0 and base<MEM_SIZE.
  - IDLE → DONE: on cmd handshake with len=0.
  - IDLE → ERR: on cmd handshake with base>=MEM_SIZE.
  - READ → DRAIN: on the advancing cycle that issues the last read.
  - DRAIN → DONE: when the final beat handshakes.
  - DONE → IDLE and ERR → IDLE: after one cycle.
- cmd_ready = (state==IDLE).
- Pipeline advance: adv = !v1 || out_ready.
  - v0: a read is held in the RAM's first stage.
  - v1: a read is held in the RAM's output stage.
  - ram_ce = adv && (state==READ || state==DRAIN).
- On every clk edge with ram_ce=1: v1<=v0; v0<=(state==READ).
  - In READ, ram_addr is the current issue address.
  - In DRAIN, ram_addr holds its last value.
- Output path: out_data = ram_q (combinational passthrough); out_valid = v1.
  - ram_q is stable while ram_ce=0, so data holds under backpressure as required.
- Issue address: starts at cmd_base and increments per issued read.
  - Wrap: MEM_SIZE-1 → 0 (circular-buffer read).
  - Bursts with base+len > MEM_SIZE are legal and wrap.
  - len > MEM_SIZE re-reads words.
- Latency: command handshake at edge E0 → first ram_ce cycle after E0 → out_valid high after E2.
- Throughput: 1 word/cycle with out_ready=1.
- done: registered, high for the single cycle after the final out handshake (DONE state). A new command may be accepted in that cycle's successor (IDLE).
- len=0: no reads issued, out_valid never rises, done pulses the cycle after acceptance.
- err: pulses the cycle after acceptance of a command with base>=MEM_SIZE. No reads are issued and done is not asserted.
- cmd_valid outside IDLE: ignored.
- Reset mid-burst: in-flight reads are discarded (v0, v1 cleared) and out_valid drops immediately. RAM contents are unaffected.

Optional Feature:
- Macro: RAM_STREAM_READER_LAST_EN.
- When defined: adds output port out_last (1 bit), high with out_valid on the final beat of a burst only, reset 0. It is derived from a remaining-beats counter that decrements on out handshake.
- When undefined: the port and counter logic do not exist. Completion is signalled only by done.

Test Plan:
- base=10, len=4, RAM[10..13]=A,B,C,D, out_ready=1 → out_valid from 3rd cycle after handshake, 4 consecutive beats A,B,C,D, done 1 cycle after D; with LAST_EN, out_last only on D.
- Same burst with out_ready toggling 1,0,0,1,… → beats A..D delivered in order with no loss or duplication; out_data stable while out_valid && !out_ready; ram_ce low in stalled cycles.
- base=3070, len=4, MEM_SIZE=3072 → ram_addr sequence 3070,3071,0,1; data RAM[3070],RAM[3071],RAM[0],RAM[1].
- len=0 → ram_ce never high, out_valid never high, done pulses once. base=3072 → err pulses once, no done, cmd_ready high again next cycle.
- rst asserted after 2 of 8 beats delivered → out_valid=0 and busy=0 asynchronously; new command base=0, len=2 afterwards returns RAM[0],RAM[1] correctly.
- cmd_valid held high during a len=6 burst → second command accepted only in IDLE; bursts back-to-back with no interleaving.
